regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port integer register file for the pipelined core, succeeding the single-write, two-read file of the single-cycle datapath. Provides NRD combinational read ports, NWR write ports with same-cycle write-to-read bypass, and a per-register busy scoreboard for hazard detection. After reset, a self-clearing sweep zeroes every entry before the file accepts traffic. Sits between the decode stage (reads, issue) and the writeback stage (writes).

## Interface
- XLEN, 32, data width in bits
- NREG, 32, number of architectural registers (power of two, ≥ 2)
- NRD, 2, number of read ports
- NWR, 2, number of write ports
- AW, $clog2(NREG), derived address width; not to be overridden
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high reset
- ra  in  NRD*AW  read addresses; port i at [i*AW +: AW]
- rd  out  NRD*XLEN  read data; port i at [i*XLEN +: XLEN]
- rbusy  out  NRD  scoreboard busy bit of the register addressed by ra port i
- we  in  NWR  write enables
- wa  in  NWR*AW  write addresses
- wd  in  NWR*XLEN  write data
- iss_en  in  1  mark register iss_a busy (new in-flight producer)
- iss_a  in  AW  register to mark busy
- ready  out  1  high once the clear sweep completes; file accepts traffic

## Operation
- States: CLEAR, RUN. Reset forces CLEAR, sweep counter cnt = 0, all busy bits = 0.
- CLEAR: each edge with reset low writes 0 to rf[cnt], cnt increments; at the edge where cnt == NREG-1, state → RUN. we and iss_en ignored; rd = 0, rbusy = 0, ready = 0.
- RUN: ready = 1. For each write port j with we[j] and wa[j] != 0: rf[wa[j]] ← wd[j], busy[wa[j]] ← 0.
- Write conflict (two ports, same nonzero address, same cycle): highest-index port wins.
- iss_en with iss_a != 0 sets busy[iss_a]. Issue and write to same address in same cycle: busy ends set (issue wins); data still written.
- Register 0: reads return 0, writes discarded, busy never set, rbusy always 0.
- Read port i, RUN: if ra_i == 0 → 0; else if any we[j] with wa[j] == ra_i → wd of highest such j (bypass); else rf[ra_i].
- rbusy_i reflects the registered busy bit; it is not bypassed by same-cycle writes or issues.
- Reset asserted in RUN: next edge enters CLEAR, busy cleared, full sweep reruns; prior contents lost.

## Timing
- rd, rbusy: combinational from ra, we, wa, wd and state; zero cycles latency.
- Writes and busy updates visible from the array the cycle after the edge; visible via bypass in the same cycle.
- ready rises exactly NREG rising edges after the first edge sampling reset low; reset values: ready = 0, rd = 0, rbusy = 0.
- No handshake on write/issue ports; callers must hold traffic until ready = 1 (dropped otherwise).

## Test plan
- Reset 1 cycle, release; count edges → ready = 0 for 32 edges, 1 thereafter; all 32 reads return 0x0.
- RUN: write x5 = 0xDEADBEEF on port 0; same cycle read ra0 = 5 → rd0 = 0xDEADBEEF (bypass); next cycle, no write → still 0xDEADBEEF.
- Ports 0 and 1 both write x7 (0x11, 0x22) same cycle → read x7 = 0x22 same cycle and after.
- Write x0 = 0xFFFFFFFF, iss_a = 0 → rd of x0 = 0, rbusy = 0.
- iss_en x3 → rbusy = 1 next cycle; write x3 = 0x5 → rbusy = 0 next cycle; simultaneous issue + write x3 → rbusy stays 1, x3 = new data.
- Mid-RUN reset with x9 = 0xABCD, busy x9 set → ready drops next cycle, rbusy = 0, after 32 edges x9 reads 0.

Source files
------------

// File: rtl/regfile_mp_if.sv
// rtl/regfile_mp_if.sv - read/write/issue bus of the multi-port register file
interface regfile_mp_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2,
  parameter int NWR  = 2
) ();
  localparam int AW = $clog2(NREG);

  logic [NRD*AW-1:0]   ra;
  logic [NRD*XLEN-1:0] rd;
  logic [NRD-1:0]      rbusy;
  logic [NWR-1:0]      we;
  logic [NWR*AW-1:0]   wa;
  logic [NWR*XLEN-1:0] wd;
  logic                iss_en;
  logic [AW-1:0]       iss_a;
  logic                ready;

  modport master (
    output ra, we, wa, wd, iss_en, iss_a,
    input  rd, rbusy, ready
  );

  modport slave (
    input  ra, we, wa, wd, iss_en, iss_a,
    output rd, rbusy, ready
  );
endinterface

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with write bypass, busy scoreboard and clear sweep
module regfile_mp #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2,
  parameter int NWR  = 2
) (
  input logic         clk,
  input logic         reset,
  regfile_mp_if.slave bus
);
  localparam int AW = $clog2(NREG);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t          state, state_nx;
  logic [AW-1:0]   cnt;
  logic [XLEN-1:0] rf [NREG];
  logic [NREG-1:0] busy;
  logic [AW-1:0]   ra_i [NRD];
  logic [XLEN-1:0] rdat [NRD];

  always_ff @(posedge clk) begin
    if (reset) state <= CLEAR;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (state == CLEAR && cnt == AW'(NREG - 1)) state_nx = RUN;
  end

  always_ff @(posedge clk) begin
    if (reset)               cnt <= '0;
    else if (state == CLEAR) cnt <= cnt + 1'b1;
  end

  // Later ports in the loop override earlier ones, so the highest-index writer wins.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == CLEAR) begin
        rf[cnt] <= '0;
      end else begin
        for (int j = 0; j < NWR; j++) begin
          if (bus.we[j] && bus.wa[j*AW +: AW] != '0)
            rf[bus.wa[j*AW +: AW]] <= bus.wd[j*XLEN +: XLEN];
        end
      end
    end
  end

  // Issue is applied after the write-clears so a same-cycle issue leaves the bit set.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= '0;
    end else if (state == RUN) begin
      for (int j = 0; j < NWR; j++) begin
        if (bus.we[j] && bus.wa[j*AW +: AW] != '0)
          busy[bus.wa[j*AW +: AW]] <= 1'b0;
      end
      if (bus.iss_en && bus.iss_a != '0) busy[bus.iss_a] <= 1'b1;
    end
  end

  always_comb begin
    bus.ready = (state == RUN);
    bus.rd    = '0;
    bus.rbusy = '0;
    for (int i = 0; i < NRD; i++) begin
      ra_i[i] = bus.ra[i*AW +: AW];
      rdat[i] = rf[ra_i[i]];
      for (int j = 0; j < NWR; j++) begin
        if (bus.we[j] && bus.wa[j*AW +: AW] == ra_i[i])
          rdat[i] = bus.wd[j*XLEN +: XLEN];
      end
      if (state == RUN && ra_i[i] != '0) begin
        bus.rd[i*XLEN +: XLEN] = rdat[i];
        bus.rbusy[i]           = busy[ra_i[i]];
      end
    end
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed vector bench for regfile_mp
module tb_regfile_mp;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  regfile_mp_if bus ();
  regfile_mp dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        iss_en;
    logic [4:0]  iss_a;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e_rd0;
    logic [31:0] e_rd1;
    logic [1:0]  e_busy;
  } vec_t;

  vec_t vecs [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] we, input logic [4:0] wa0, input logic [31:0] wd0,
                       input logic [4:0] wa1, input logic [31:0] wd1,
                       input logic ie, input logic [4:0] ia,
                       input logic [4:0] ra0, input logic [4:0] ra1);
    bus.we     = we;
    bus.wa     = {wa1, wa0};
    bus.wd     = {wd1, wd0};
    bus.iss_en = ie;
    bus.iss_a  = ia;
    bus.ra     = {ra1, ra0};
  endtask

  initial begin
    vecs[0]  = '{2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 2'b00};
    vecs[1]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 2'b00};
    vecs[2]  = '{2'b11, 5'd7, 32'h11, 5'd7, 32'h22, 1'b0, 5'd0, 5'd7, 5'd5, 32'h22, 32'hDEADBEEF, 2'b00};
    vecs[3]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd7, 32'h22, 32'h22, 2'b00};
    vecs[4]  = '{2'b01, 5'd0, 32'hFFFFFFFF, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00};
    vecs[5]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00};
    vecs[6]  = '{2'b10, 5'd0, 32'h0, 5'd4, 32'hCAFE, 1'b0, 5'd0, 5'd4, 5'd7, 32'hCAFE, 32'h22, 2'b00};
    vecs[7]  = '{2'b01, 5'd12, 32'h1234, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd12, 32'h22, 32'h1234, 2'b00};
    vecs[8]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd12, 32'hCAFE, 32'h1234, 2'b00};
    vecs[9]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd0, 32'h0, 32'h0, 2'b00};
    vecs[10] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd3, 32'h0, 32'h0, 2'b11};
    vecs[11] = '{2'b01, 5'd3, 32'h5, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd0, 32'h5, 32'h0, 2'b01};
    vecs[12] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd0, 32'h5, 32'h0, 2'b00};
    vecs[13] = '{2'b10, 5'd0, 32'h0, 5'd3, 32'h77, 1'b1, 5'd3, 5'd3, 5'd0, 32'h77, 32'h0, 2'b00};
    vecs[14] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd3, 32'h77, 32'h77, 2'b11};
    vecs[15] = '{2'b01, 5'd9, 32'hABCD, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd3, 32'hABCD, 32'h77, 2'b10};
    vecs[16] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd3, 32'hABCD, 32'h77, 2'b11};
    vecs[17] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd5, 32'h22, 32'hDEADBEEF, 2'b00};

    reset = 1'b1;
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd1, 5'd2);
    @(posedge clk);
    #1;
    chk("reset_ready", {31'b0, bus.ready}, 32'h0);
    chk("reset_rd", bus.rd[31:0] | bus.rd[63:32], 32'h0);
    chk("reset_rbusy", {30'b0, bus.rbusy}, 32'h0);

    @(negedge clk);
    reset = 1'b0;
    for (int e = 1; e <= 34; e++) begin
      @(posedge clk);
      #1;
      chk($sformatf("sweep_ready_e%0d", e), {31'b0, bus.ready}, (e >= 32) ? 32'h1 : 32'h0);
      if (e < 32) chk($sformatf("sweep_rd_e%0d", e), bus.rd[31:0], 32'h0);
    end

    for (int r = 0; r < 32; r++) begin
      @(negedge clk);
      drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'(r), 5'(31 - r));
      #1;
      chk($sformatf("clear_x%0d", r), bus.rd[31:0], 32'h0);
    end

    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      drive(vecs[k].we, vecs[k].wa0, vecs[k].wd0, vecs[k].wa1, vecs[k].wd1,
            vecs[k].iss_en, vecs[k].iss_a, vecs[k].ra0, vecs[k].ra1);
      #1;
      chk($sformatf("v%0d_rd0", k), bus.rd[31:0], vecs[k].e_rd0);
      chk($sformatf("v%0d_rd1", k), bus.rd[63:32], vecs[k].e_rd1);
      chk($sformatf("v%0d_rbusy", k), {30'b0, bus.rbusy}, {30'b0, vecs[k].e_busy});
    end

    // Mid-run reset with x9 busy; traffic driven during the sweep must be dropped.
    @(negedge clk);
    reset = 1'b1;
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd6);
    @(posedge clk);
    #1;
    chk("mid_reset_ready", {31'b0, bus.ready}, 32'h0);
    chk("mid_reset_rbusy", {30'b0, bus.rbusy}, 32'h0);
    chk("mid_reset_rd0", bus.rd[31:0], 32'h0);
    @(negedge clk);
    reset = 1'b0;
    drive(2'b01, 5'd6, 32'h66, 5'd0, 32'h0, 1'b1, 5'd6, 5'd9, 5'd6);
    for (int e = 1; e <= 33; e++) begin
      @(posedge clk);
      #1;
      chk($sformatf("resweep_ready_e%0d", e), {31'b0, bus.ready}, (e >= 32) ? 32'h1 : 32'h0);
      if (e == 31) drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd6);
    end
    @(negedge clk);
    chk("resweep_x9", bus.rd[31:0], 32'h0);
    chk("resweep_x6", bus.rd[63:32], 32'h0);
    chk("resweep_rbusy", {30'b0, bus.rbusy}, 32'h0);
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd7);
    #1;
    chk("resweep_x5", bus.rd[31:0], 32'h0);
    chk("resweep_x7", bus.rd[63:32], 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
